// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a little-endian byte stream into 32-bit words at addresses 0..N-1.
// Write strobe 1 cycle after the 4th byte of each word, Done 1 cycle after the final write; bytes only accepted in RECV.
module imem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [CNT_WIDTH-1:0]  WordCount,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteData,
  output logic                  ByteReady,
  output logic                  MemWriteEnable,
  output logic [ADDR_WIDTH-1:0] MemWriteAddress,
  output logic [31:0]           MemWriteData,
  output logic                  Busy,
  output logic                  Done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  count;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [23:0]           partial;
  logic                  xfer;

  assign xfer = ByteValid && ByteReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      word_idx        <= '0;
      lane            <= '0;
      partial         <= '0;
      ByteReady       <= 1'b0;
      MemWriteEnable  <= 1'b0;
      MemWriteAddress <= '0;
      MemWriteData    <= '0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
    end else begin
      MemWriteEnable <= 1'b0;
      Done           <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            count    <= (WordCount > MAX_WORDS) ? MAX_WORDS : WordCount;
            word_idx <= '0;
            lane     <= '0;
            if (WordCount == '0) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state     <= RECV;
              ByteReady <= 1'b1;
              Busy      <= 1'b1;
            end
          end
        end
        RECV: begin
          if (xfer) begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: partial[7:0]   <= ByteData;
              2'd1: partial[15:8]  <= ByteData;
              2'd2: partial[23:16] <= ByteData;
              default: begin
                // Top lane goes straight to the output register, so the word is ready in WRITE.
                state           <= WRITE;
                ByteReady       <= 1'b0;
                MemWriteEnable  <= 1'b1;
                MemWriteAddress <= word_idx;
                MemWriteData    <= {ByteData, partial};
              end
            endcase
          end
        end
        WRITE: begin
          if (CNT_WIDTH'(word_idx) == count - CNT_WIDTH'(1)) begin
            state <= DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            word_idx  <= word_idx + 1'b1;
            lane      <= '0;
            state     <= RECV;
            ByteReady <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: transaction-level expected-write queue plus per-cycle handshake timing checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, Start, ByteValid;
  logic [5:0]  WordCount;
  logic [7:0]  ByteData;
  logic        ByteReady, MemWriteEnable, Busy, Done;
  logic [4:0]  MemWriteAddress;
  logic [31:0] MemWriteData;

  imem_loader dut (
    .clk(clk), .reset(reset), .Start(Start), .WordCount(WordCount),
    .ByteValid(ByteValid), .ByteData(ByteData), .ByteReady(ByteReady),
    .MemWriteEnable(MemWriteEnable), .MemWriteAddress(MemWriteAddress),
    .MemWriteData(MemWriteData), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [4:0] a; logic [31:0] d; int c; } log_t;

  int checks = 0, failures = 0, cyc = 0;
  wr_t  exp_q[$];
  log_t wlog[$];
  logic [7:0] src_q[$];
  logic [7:0] bq[$];
  bit   rand_valid = 0, mon_on = 0;
  int   lw_cnt = 0, acc = 0, done_seen = 0;
  logic we_due = 0, done_due = 0, exp_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte source: holds the front byte until a handshake is seen, optionally gaps valid.
  initial begin
    logic hs;
    forever begin
      @(negedge clk);
      hs = ByteValid && ByteReady && !reset;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 1) == 1)) begin
        ByteValid = 1'b1;
        ByteData  = src_q[0];
      end else begin
        ByteValid = 1'b0;
      end
    end
  end

  // Monitor: every write must match the next expected word and land one cycle after every 4th accepted byte.
  always @(negedge clk) begin
    logic hs, start_ok, last_write;
    wr_t  e;
    if (mon_on) begin
      chk("write_strobe", MemWriteEnable, we_due);
      if (MemWriteEnable === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("write_addr", MemWriteAddress, e.a);
          chk("write_data", MemWriteData, e.d);
        end
        wlog.push_back('{MemWriteAddress, MemWriteData, cyc});
      end
      chk("done_pulse", Done, done_due);
      if (Done === 1'b1) done_seen++;
      chk("busy", Busy, exp_busy);
      chk("ready_only_receiving", ByteReady && !(Busy && !MemWriteEnable), 0);
      hs         = ByteValid && ByteReady;
      start_ok   = Start && !Busy && !Done;
      last_write = MemWriteEnable && exp_q.size() == 0;
      if (reset) begin
        we_due = 0; done_due = 0; exp_busy = 0; acc = 0;
        exp_q.delete();
      end else begin
        we_due = hs && (acc % 4 == 3);
        if (hs) acc++;
        done_due = last_write || (start_ok && lw_cnt == 0);
        if (start_ok) begin
          acc = 0;
          exp_busy = (lw_cnt != 0);
        end else if (last_write) exp_busy = 0;
      end
      cyc++;
    end
  end

  task automatic load(input int cnt);
    int n;
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{i[4:0], {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]}});
    foreach (bq[i]) src_q.push_back(bq[i]);
    wlog.delete();
    lw_cnt = n;
    @(posedge clk); #2;
    Start = 1'b1; WordCount = cnt[5:0];
    @(posedge clk); #2;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 3000 && done_seen == d0; i++) @(posedge clk);
    chk(name, done_seen != d0, 1);
    #2;
    src_q.delete();
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic set_word1();
    bq = '{8'h93, 8'h01, 8'h10, 8'h00};
  endtask

  initial begin
    int d0;
    reset = 1'b1; Start = 1'b0; WordCount = '0; ByteValid = 1'b0; ByteData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ByteReady, 0);
    chk("rst_we", MemWriteEnable, 0);
    chk("rst_addr", MemWriteAddress, 0);
    chk("rst_data", MemWriteData, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    mon_on = 1;

    // Single word, continuous valid.
    set_word1();
    load(1);
    wait_done("t1_done");
    chk("t1_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("t1_addr", wlog[0].a, 0);
      chk("t1_data", wlog[0].d, 32'h00100193);
    end

    // Three words back to back: 5-cycle word rate.
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'h11 + 8'(i));
    load(3);
    wait_done("t2_done");
    chk("t2_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t2_data0", wlog[0].d, 32'h14131211);
      chk("t2_data2", wlog[2].d, 32'h1C1B1A19);
      chk("t2_addr2", wlog[2].a, 2);
      chk("t2_gap01", wlog[1].c - wlog[0].c, 5);
      chk("t2_gap12", wlog[2].c - wlog[1].c, 5);
    end

    // Gappy valid within words.
    rand_valid = 1;
    set_word1();
    bq.push_back(8'hA1); bq.push_back(8'hB2); bq.push_back(8'hC3); bq.push_back(8'hD4);
    load(2);
    wait_done("t3_done");
    chk("t3_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t3_data0", wlog[0].d, 32'h00100193);
      chk("t3_data1", wlog[1].d, 32'hD4C3B2A1);
    end
    rand_valid = 0;

    // Zero count: Done right after Start, no write.
    bq.delete();
    load(0);
    wait_done("t4a_done");
    chk("t4a_nwrites", wlog.size(), 0);

    // Oversized count clamps to the full 32-word memory.
    bq.delete();
    for (int i = 0; i < 160; i++) bq.push_back(8'(i));
    load(40);
    wait_done("t4b_done");
    chk("t4b_nwrites", wlog.size(), 32);
    if (wlog.size() == 32) begin
      chk("t4b_last_addr", wlog[31].a, 31);
      chk("t4b_last_data", wlog[31].d, 32'h7F7E7D7C);
    end

    // Reset two bytes into word 1: no further write, no Done, clean restart.
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'h40 + 8'(i));
    load(2);
    for (int i = 0; i < 200 && acc < 6; i++) @(posedge clk);
    chk("t5_reached_6_bytes", acc >= 6, 1);
    #2;
    d0 = done_seen;
    reset = 1'b1;
    src_q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    chk("t5_no_done", done_seen - d0, 0);
    chk("t5_nwrites", wlog.size(), 1);
    set_word1();
    load(1);
    wait_done("t5_restart_done");
    chk("t5_restart_n", wlog.size(), 1);
    if (wlog.size() == 1) chk("t5_restart_data", wlog[0].d, 32'h00100193);

    // Start during RECV is ignored.
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'hE0 + 8'(i));
    load(3);
    for (int i = 0; i < 200 && acc < 5; i++) @(posedge clk);
    #2;
    Start = 1'b1; WordCount = 6'd1;
    @(posedge clk); #2;
    Start = 1'b0;
    wait_done("t6_done");
    chk("t6_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t6_addr1", wlog[1].a, 1);
      chk("t6_data1", wlog[1].d, 32'hE7E6E5E4);
    end
    chk("t6_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
